// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline stage.
//
// Purpose:
//   Drives the register file read addresses from the instruction in ID and forwards a
//   same-cycle WB write onto the operands. Generates the RV32I immediate and detects
//   load-use hazards, inserting a bubble and stalling ID. Captures operands and control
//   into the ID/EX pipeline register that EX consumes.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   id_valid/pc/instr    instruction currently held in ID
//   rs1_addr, rs2_addr   register file read addresses (instr[19:15], instr[24:20])
//   rs1_data, rs2_data   register file read data
//   wb_we/rd/data        register file write port driven by WB this cycle
//   ex_stall             EX cannot accept; hold the ID/EX register
//   flush                taken branch/jump; kill the ID->EX transfer
//   id_stall             hold PC and the IF/ID register
//   ex_*                 ID/EX pipeline register contents
module id_ex_stage #(
  parameter int unsigned WID_DATA = 32,
  parameter int unsigned WID_ADD  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_instr,
  output logic [WID_ADD-1:0]  rs1_addr,
  output logic [WID_ADD-1:0]  rs2_addr,
  input  logic [WID_DATA-1:0] rs1_data,
  input  logic [WID_DATA-1:0] rs2_data,
  input  logic                wb_we,
  input  logic [WID_ADD-1:0]  wb_rd,
  input  logic [WID_DATA-1:0] wb_data,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [WID_DATA-1:0] ex_rs1_val,
  output logic [WID_DATA-1:0] ex_rs2_val,
  output logic [31:0]         ex_imm,
  output logic [WID_ADD-1:0]  ex_rd,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic                ex_funct7b5,
  output logic                ex_is_load,
  output logic                ex_reg_we
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [6:0]          opcode;
  logic [WID_ADD-1:0]  rd;
  logic                uses_rs1;
  logic                uses_rs2;
  logic                is_load;
  logic                reg_we;
  logic [31:0]         imm;
  logic [WID_DATA-1:0] rs1_fwd;
  logic [WID_DATA-1:0] rs2_fwd;
  logic                hz;

  assign opcode   = id_instr[6:0];
  assign rd       = WID_ADD'(id_instr[11:7]);
  assign rs1_addr = WID_ADD'(id_instr[19:15]);
  assign rs2_addr = WID_ADD'(id_instr[24:20]);

  // Decode: register usage, control bits and immediate.
  always_comb begin
    uses_rs1 = !(opcode inside {OpLui, OpAuipc, OpJal});
    uses_rs2 = opcode inside {OpOp, OpStore, OpBranch};
    is_load  = (opcode == OpLoad);
    reg_we   = (rd != '0) && !(opcode inside {OpStore, OpBranch});
    imm      = '0;
    case (opcode)
      OpLoad, OpImm, OpJalr, OpSystem, OpMisc: begin
        imm = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OpStore: begin
        imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      OpBranch: begin
        imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
               id_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        imm = {id_instr[31:12], 12'b0};
      end
      OpJal: begin
        imm = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
               id_instr[30:21], 1'b0};
      end
      default: imm = '0;
    endcase
  end

  // WB bypass: the register file is read and written in the same cycle, so the
  // write data must be forwarded here. x0 always reads as zero.
  always_comb begin
    if (rs1_addr == '0) begin
      rs1_fwd = '0;
    end else if (wb_we && (wb_rd == rs1_addr)) begin
      rs1_fwd = wb_data;
    end else begin
      rs1_fwd = rs1_data;
    end
    if (rs2_addr == '0) begin
      rs2_fwd = '0;
    end else if (wb_we && (wb_rd == rs2_addr)) begin
      rs2_fwd = wb_data;
    end else begin
      rs2_fwd = rs2_data;
    end
  end

  // Load-use: the load in EX produces its data too late for the instruction in ID.
  assign hz = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
              ((uses_rs1 && (ex_rd == rs1_addr)) || (uses_rs2 && (ex_rd == rs2_addr)));

  assign id_stall = (hz || ex_stall) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_reg_we   <= 1'b0;
    end else if (flush) begin
      // Flush wins over ex_stall: the held instruction is on the wrong path.
      ex_valid   <= 1'b0;
      ex_reg_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_stall) begin
      // Hold everything; a pending hazard is re-evaluated once EX frees up.
    end else if (hz) begin
      // Bubble; payload fields are left as-is since nothing consumes them.
      ex_valid   <= 1'b0;
      ex_reg_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_val  <= rs1_fwd;
      ex_rs2_val  <= rs2_fwd;
      ex_imm      <= imm;
      ex_rd       <= rd;
      ex_opcode   <= opcode;
      ex_funct3   <= id_instr[14:12];
      ex_funct7b5 <= id_instr[30];
      ex_is_load  <= id_valid && is_load;
      ex_reg_we   <= id_valid && reg_we;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. A driver applies directed and random
// stimulus, predicts the ID/EX register contents and id_stall from a behavioural model,
// and queues the predictions; two monitors pop and compare against the DUT.
module tb_id_ex_stage;

  localparam logic [6:0] LOAD = 7'b0000011, MISC = 7'b0001111, OPIMM = 7'b0010011;
  localparam logic [6:0] AUIPC = 7'b0010111, STORE = 7'b0100011, OP = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111, BRANCH = 7'b1100011, JALR = 7'b1100111;
  localparam logic [6:0] JAL = 7'b1101111, SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, id_valid, wb_we, ex_stall, flush;
  logic [31:0] id_pc, id_instr, rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic        id_stall, ex_valid, ex_funct7b5, ex_is_load, ex_reg_we;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  id_ex_stage #(.WID_DATA(32), .WID_ADD(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load),
    .ex_reg_we(ex_reg_we)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f7b5;
    logic        is_load;
    logic        reg_we;
  } ex_t;

  typedef struct packed {
    logic full;  // payload fields are meaningful (live instruction or reset)
    ex_t  e;
  } exp_t;

  typedef struct packed {
    logic       stall;
    logic [4:0] a1;
    logic [4:0] a2;
  } st_t;

  exp_t        exp_q[$];
  st_t         st_q[$];
  ex_t         m;
  logic [31:0] regs[32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate built by placing the field at the top of a word and arithmetic-shifting.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic signed [31:0] w;
    case (ins[6:0])
      LOAD, OPIMM, JALR, SYSTEM, MISC: begin
        w = ins;
        return w >>> 20;
      end
      STORE: begin
        w = {ins[31:25], ins[11:7], 20'b0};
        return w >>> 20;
      end
      BRANCH: begin
        w = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0};
        return w >>> 19;
      end
      LUI, AUIPC: return {ins[31:12], 12'b0};
      JAL: begin
        w = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0};
        return w >>> 11;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return rf;
  endfunction

  // Apply current inputs, predict this cycle's id_stall and the next ID/EX contents.
  task automatic step();
    logic [4:0] r1, r2, rd;
    logic [6:0] op;
    logic       use1, use2, hz;
    ex_t        nx;
    r1 = id_instr[19:15];
    r2 = id_instr[24:20];
    rd = id_instr[11:7];
    op = id_instr[6:0];
    rs1_data = regs[r1];
    rs2_data = regs[r2];
    use1 = !(op inside {LUI, AUIPC, JAL});
    use2 = op inside {OP, STORE, BRANCH};
    hz = id_valid && m.valid && m.is_load && (m.rd != 0) &&
         ((use1 && m.rd == r1) || (use2 && m.rd == r2));
    st_q.push_back('{stall: (hz || ex_stall) && !rst, a1: r1, a2: r2});
    nx = m;
    if (rst) begin
      nx = '0;
    end else if (flush || (!ex_stall && hz)) begin
      nx.valid = 1'b0;
      nx.is_load = 1'b0;
      nx.reg_we = 1'b0;
    end else if (!ex_stall) begin
      nx.valid = id_valid;
      nx.pc = id_pc;
      nx.rs1 = operand(r1, regs[r1]);
      nx.rs2 = operand(r2, regs[r2]);
      nx.imm = ref_imm(id_instr);
      nx.rd = rd;
      nx.opcode = op;
      nx.f3 = id_instr[14:12];
      nx.f7b5 = id_instr[30];
      nx.is_load = id_valid && (op == LOAD);
      nx.reg_we = id_valid && (rd != 0) && !(op inside {STORE, BRANCH});
    end
    m = nx;
    exp_q.push_back('{full: rst || nx.valid, e: nx});
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] ins);
    id_instr = ins;
    id_pc = id_pc + 32'd4;
    step();
  endtask

  // Monitor: ID/EX register, one prediction per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(x.e.valid));
        chk("ex_is_load", 32'(ex_is_load), 32'(x.e.is_load));
        chk("ex_reg_we", 32'(ex_reg_we), 32'(x.e.reg_we));
        if (x.full) begin
          chk("ex_pc", ex_pc, x.e.pc);
          chk("ex_rs1_val", ex_rs1_val, x.e.rs1);
          chk("ex_rs2_val", ex_rs2_val, x.e.rs2);
          chk("ex_imm", ex_imm, x.e.imm);
          chk("ex_rd", 32'(ex_rd), 32'(x.e.rd));
          chk("ex_opcode", 32'(ex_opcode), 32'(x.e.opcode));
          chk("ex_funct3", 32'(ex_funct3), 32'(x.e.f3));
          chk("ex_funct7b5", 32'(ex_funct7b5), 32'(x.e.f7b5));
        end
      end
    end
  end

  // Monitor: combinational stall and read addresses, mid-cycle after inputs settle.
  initial begin
    st_t s;
    #3;
    forever begin
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("id_stall", 32'(id_stall), 32'(s.stall));
        chk("rs1_addr", 32'(rs1_addr), 32'(s.a1));
        chk("rs2_addr", 32'(rs2_addr), 32'(s.a2));
      end
      @(posedge clk);
      #4;
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5_M1 = 32'hFFF0_0293;
  localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
  localparam logic [31:0] LW_X4 = 32'h0000_A203;
  localparam logic [31:0] ADD_X6_X4_X4 = 32'h0042_0333;
  localparam logic [31:0] LUI_X4 = 32'h0002_0237;  // rs1 field happens to be x4

  initial begin
    logic [6:0] ops[11];
    logic [31:0] ins;
    ops = '{LOAD, MISC, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM};
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    m = '0;
    rst = 1'b1; id_valid = 1'b1; id_pc = 32'h100; id_instr = NOP;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_stall = 1'b0; flush = 1'b0;

    // Reset for two cycles, then a NOP is captured.
    step();
    chk("rst_id_stall", 32'(id_stall), 32'd0);
    tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    step();
    tick();
    rst = 1'b0;
    issue(NOP);
    tick();
    chk("nop_ex_valid", 32'(ex_valid), 32'd1);

    // ADDI x5,x0,-1: x0 reads as zero even with garbage and a WB write to x0.
    regs[0] = 32'hDEAD_BEEF;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    issue(ADDI_X5_M1);
    tick();
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(ex_rd), 32'd5);
    chk("addi_reg_we", 32'(ex_reg_we), 32'd1);
    chk("addi_rs1", ex_rs1_val, 32'd0);

    // WB bypass onto rs1, then no bypass when WB targets x0.
    regs[1] = 32'd7;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    issue(ADD_X3_X1_X2);
    tick();
    chk("bypass_rs1", ex_rs1_val, 32'd9);
    wb_rd = 5'd0;
    issue(ADD_X3_X1_X2);
    tick();
    chk("nobypass_rs1", ex_rs1_val, 32'd7);
    wb_we = 1'b0;

    // Load-use: one bubble, then the consumer is captured. LUI does not read rs1.
    issue(LW_X4);
    tick();
    issue(ADD_X6_X4_X4);
    chk("lu_stall", 32'(id_stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step();
    chk("lu_release", 32'(id_stall), 32'd0);
    tick();
    chk("lu_capture_v", 32'(ex_valid), 32'd1);
    chk("lu_capture_rd", 32'(ex_rd), 32'd6);
    issue(LW_X4);
    tick();
    issue(LUI_X4);
    chk("lui_nostall", 32'(id_stall), 32'd0);
    tick();

    // EX stall holds an ADD for three cycles, then flush during the stall kills it.
    issue(ADD_X3_X1_X2);
    tick();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ADDI_X5_M1);
      chk("exst_stall", 32'(id_stall), 32'd1);
      tick();
      chk("exst_hold_rd", 32'(ex_rd), 32'd3);
    end
    flush = 1'b1;
    step();
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // Reset during a load-use stall.
    issue(LW_X4);
    tick();
    rst = 1'b1;
    issue(ADD_X6_X4_X4);
    chk("rst_hz_stall", 32'(id_stall), 32'd0);
    tick();
    chk("rst_hz_valid", 32'(ex_valid), 32'd0);
    chk("rst_hz_pc", ex_pc, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_stall", 32'(id_stall), 32'd0);
    tick();

    // Random traffic on a small register window so hazards and bypasses are frequent.
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      regs[$urandom_range(0, 31)] = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      wb_we = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      id_pc = $urandom;
      id_instr = ins;
      step();
      tick();
    end

    #5;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("st_q_drained", 32'(st_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
